mux_rr_arbiter: RTL and testbench

- Shares one key-selected data mux (MuxKey, key = source index) between NR_REQ requesters.
- Round-robin arbitration; a multi-beat burst holds the grant until its last beat.
- Output is a one-entry register with a valid/ready handshake.
- Sits between the per-source input buses and one downstream consumer of the selected data.

---
 rtl/mux_rr_arbiter_if.sv | 37 +++
 rtl/mux_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: bundles the per-source request bus and the registered
// output bus of mux_rr_arbiter.
//   master : the requesters plus the downstream consumer (drives req_*, out_ready)
//   slave  : the arbiter (drives req_ready, out_*, burst_trunc)
// Signals:
//   req_valid/req_last [NR_REQ]    per-source beat valid / last-beat flag
//   req_data [NR_REQ*DATA_LEN]     packed beats, source n at [n*DATA_LEN +: DATA_LEN]
//   req_ready [NR_REQ]             per-source accept, at most one bit set
//   out_valid/out_data/out_src/out_last  one-entry output register
//   out_ready                      consumer accept
//   burst_trunc                    one-cycle pulse when a burst is cut at MAX_BURST
interface mux_rr_arbiter_if #(
  parameter int NR_REQ   = 4,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 2
);
  logic [NR_REQ-1:0]          req_valid;
  logic [NR_REQ-1:0]          req_last;
  logic [NR_REQ*DATA_LEN-1:0] req_data;
  logic [NR_REQ-1:0]          req_ready;
  logic                       out_valid;
  logic [DATA_LEN-1:0]        out_data;
  logic [SEL_LEN-1:0]         out_src;
  logic                       out_last;
  logic                       out_ready;
  logic                       burst_trunc;

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, out_last, burst_trunc
  );

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, out_last, burst_trunc
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter in front of one key-selected data mux.
// A multi-beat burst keeps the grant until its last beat or until MAX_BURST
// beats have passed; the selected beat lands in a one-entry output register
// with a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_rr_arbiter_if.slave (request bus in, registered output bus out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no burst open; the first valid source from ptr onward wins
// LOCK  | burst from owner in progress; only owner may be accepted
module mux_rr_arbiter #(
  parameter int NR_REQ    = 4,
  parameter int SEL_LEN   = 2,
  parameter int DATA_LEN  = 2,
  parameter int MAX_BURST = 4
) (
  input logic            clk,
  input logic            rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam int CNT_LEN = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [SEL_LEN-1:0]  ptr_q, ptr_d;
  logic [SEL_LEN-1:0]  owner_q, owner_d;
  logic [CNT_LEN-1:0]  beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic [SEL_LEN-1:0]  out_src_q, out_src_d;
  logic                out_last_q, out_last_d;
  logic                burst_trunc_q, burst_trunc_d;

  logic                can_load;
  logic                win_found;
  logic [SEL_LEN-1:0]  win_idx;
  logic [SEL_LEN-1:0]  xfer_idx;
  logic [NR_REQ-1:0]   grant;
  logic                xfer;
  logic [DATA_LEN-1:0] sel_data;
  logic                sel_last;
  logic [CNT_LEN-1:0]  cnt_inc;
  logic                hit_max;
  logic                eff_last;

  // (a + b) mod NR_REQ for b < NR_REQ; avoids a general divider.
  function automatic logic [SEL_LEN-1:0] wrap_add(input logic [SEL_LEN-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NR_REQ) s = s - NR_REQ;
    return SEL_LEN'(s);
  endfunction

  // A beat can be loaded when the output register is empty or being drained.
  assign can_load = !out_valid_q | bus.out_ready;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!win_found && bus.req_valid[wrap_add(ptr_q, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, i);
      end
    end
  end

  always_comb begin
    grant    = '0;
    xfer_idx = (state_q == ST_LOCK) ? owner_q : win_idx;
    if (rst_n && can_load) begin
      if (state_q == ST_LOCK) grant[owner_q] = 1'b1;
      else if (win_found)     grant[win_idx] = 1'b1;
    end
  end

  assign bus.req_ready = grant;
  assign xfer          = |(bus.req_valid & grant);

  // Key-selected mux: source index is the key, no match yields zero.
  always_comb begin
    sel_data = '0;
    for (int n = 0; n < NR_REQ; n++) begin
      if (xfer_idx == SEL_LEN'(n)) sel_data = bus.req_data[n*DATA_LEN +: DATA_LEN];
    end
  end

  assign sel_last = bus.req_last[xfer_idx];
  assign cnt_inc  = beat_cnt_q + CNT_LEN'(1);
  assign hit_max  = (cnt_inc == CNT_LEN'(MAX_BURST));
  assign eff_last = sel_last | hit_max;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    beat_cnt_d    = beat_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    out_last_d    = out_last_q;
    burst_trunc_d = 1'b0;

    if (xfer) begin
      out_valid_d   = 1'b1;
      out_data_d    = sel_data;
      out_src_d     = xfer_idx;
      out_last_d    = eff_last;
      burst_trunc_d = hit_max & !sel_last;
      if (eff_last) begin
        // Pointer only advances at a burst end, so a truncated source
        // re-enters arbitration behind everyone else.
        state_d    = ST_IDLE;
        ptr_d      = wrap_add(xfer_idx, 1);
        beat_cnt_d = '0;
      end else begin
        state_d    = ST_LOCK;
        owner_d    = xfer_idx;
        beat_cnt_d = cnt_inc;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      beat_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= '0;
      out_last_q    <= 1'b0;
      burst_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      beat_cnt_q    <= beat_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      out_last_q    <= out_last_d;
      burst_trunc_q <= burst_trunc_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_src     = out_src_q;
  assign bus.out_last    = out_last_q;
  assign bus.burst_trunc = burst_trunc_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_mux_rr_arbiter;
  localparam int NR = 4;
  localparam int SL = 2;
  localparam int DL = 2;
  localparam int MB = 4;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   n_checks;
  int   n_fail;

  mux_rr_arbiter_if #(.NR_REQ(NR), .SEL_LEN(SL), .DATA_LEN(DL)) bus ();

  mux_rr_arbiter #(.NR_REQ(NR), .SEL_LEN(SL), .DATA_LEN(DL), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit             m_locked;
  int             m_owner;
  int             m_ptr;
  int             m_cnt;
  bit             m_ov;
  logic [DL-1:0]  m_od;
  int             m_os;
  bit             m_ol;
  bit             m_bt;

  function automatic logic [NR-1:0] m_ready();
    logic [NR-1:0] r;
    int n;
    bit done;
    r = '0;
    done = 1'b0;
    if (rst_n && (!m_ov || bus.out_ready)) begin
      if (m_locked) r[m_owner] = 1'b1;
      else begin
        for (int i = 0; i < NR; i++) begin
          n = (m_ptr + i) % NR;
          if (!done && bus.req_valid[n]) begin
            r[n] = 1'b1;
            done = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic int m_k();
    logic [NR-1:0] x;
    int k;
    x = m_ready() & bus.req_valid;
    k = -1;
    for (int i = 0; i < NR; i++) if (x[i]) k = i;
    return k;
  endfunction

  function automatic bit m_last();
    int k;
    k = m_k();
    return bus.req_last[k] || (m_cnt + 1 == MB);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_locked <= 1'b0; m_owner <= 0; m_ptr <= 0; m_cnt <= 0;
      m_ov <= 1'b0; m_od <= '0; m_os <= 0; m_ol <= 1'b0; m_bt <= 1'b0;
    end else if (m_k() >= 0) begin
      m_ov <= 1'b1;
      m_od <= bus.req_data[m_k()*DL +: DL];
      m_os <= m_k();
      m_ol <= m_last();
      m_bt <= m_last() && !bus.req_last[m_k()];
      if (m_last()) begin
        m_locked <= 1'b0;
        m_ptr    <= (m_k() + 1) % NR;
        m_cnt    <= 0;
      end else begin
        m_locked <= 1'b1;
        m_owner  <= m_k();
        m_cnt    <= m_cnt + 1;
      end
    end else begin
      m_bt <= 1'b0;
      if (m_ov && bus.out_ready) m_ov <= 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",   32'(bus.req_ready),   32'(m_ready()));
      chk("out_valid",   32'(bus.out_valid),   32'(m_ov));
      chk("out_data",    32'(bus.out_data),    32'(m_od));
      chk("out_src",     32'(bus.out_src),     32'(m_os));
      chk("out_last",    32'(bus.out_last),    32'(m_ol));
      chk("burst_trunc", 32'(bus.burst_trunc), 32'(m_bt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp1[5] = '{0, 1, 2, 3, 0};
  int exp3[7] = '{1, 1, 1, 1, 2, 1, 1};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    step();
    chk_en = 1'b1;
    bus.req_valid = 4'b1111;
    #1 chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_src",   32'(bus.out_src),   32'h0);

    // all sources valid, single-beat bursts
    rst_n = 1'b1;
    bus.req_last  = 4'b1111;
    bus.req_data  = 8'he4;
    bus.out_ready = 1'b1;
    chk("t1_pre_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_src", 32'(bus.out_src), 32'(exp1[i]));
      chk("t1_valid", 32'(bus.out_valid), 32'h1);
    end

    // move ptr to 2, then a 3-beat burst from src 2 with 0 and 3 waiting
    bus.req_valid = 4'b0010;
    step();
    for (int b = 1; b <= 3; b++) begin
      bus.req_valid = 4'b1101;
      bus.req_data[2*DL +: DL] = DL'(b);
      bus.req_last = (b == 3) ? 4'b1111 : 4'b1011;
      step();
      chk("t2_src",  32'(bus.out_src),  32'h2);
      chk("t2_data", 32'(bus.out_data), 32'(b));
      chk("t2_last", 32'(bus.out_last), 32'(b == 3));
    end
    bus.req_valid = 4'b1001;
    step();
    chk("t2_next3", 32'(bus.out_src), 32'h3);
    step();
    chk("t2_next0", 32'(bus.out_src), 32'h0);

    // src 1 never asserts last for 6 beats, src 2 competing
    bus.req_valid = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      bus.req_last = (i == 6) ? 4'b1111 : 4'b1101;
      step();
      chk("t3_src", 32'(bus.out_src), 32'(exp3[i]));
      if (i == 3) begin
        chk("t3_trunc", 32'(bus.burst_trunc), 32'h1);
        chk("t3_last",  32'(bus.out_last),    32'h1);
      end
      if (i == 4) chk("t3_trunc_pulse", 32'(bus.burst_trunc), 32'h0);
    end

    // backpressure: 3 stalled cycles then drain+load together
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_src",   32'(bus.out_src),   32'h2);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("t4_ready0",     32'(bus.req_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1 chk("t4_ready_back", 32'(bus.req_ready), 32'h8);
    step();
    chk("t4_load_src",   32'(bus.out_src),   32'h3);
    chk("t4_load_valid", 32'(bus.out_valid), 32'h1);

    // reset in the middle of a src 3 burst
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b0000;
    step();
    step();
    chk("t5_locked3", 32'(bus.out_src), 32'h3);
    rst_n = 1'b0;
    step();
    chk("t5_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b1111;
    step();
    chk("t5_first_src0", 32'(bus.out_src), 32'h0);

    // owner drops valid inside LOCK while src 0 waits
    bus.req_valid = 4'b0010;
    bus.req_last  = 4'b0000;
    step();
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t6_owner_only", 32'(bus.req_ready), 32'h2);
      chk("t6_idle_out",   32'(bus.out_valid), 32'h0);
    end
    bus.req_valid = 4'b0011;
    bus.req_last  = 4'b0010;
    step();
    chk("t6_resume_src",  32'(bus.out_src),  32'h1);
    chk("t6_resume_last", 32'(bus.out_last), 32'h1);
    bus.req_valid = 4'b0001;
    step();
    chk("t6_src0", 32'(bus.out_src), 32'h0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.req_valid = NR'($urandom);
      bus.req_last  = NR'($urandom & $urandom);
      bus.req_data  = (NR*DL)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
